tmp_meas_sched: RTL and testbench

Measurement scheduler for the switched-capacitor temperature-sensor core controller.
- On request, resets the core, waits a settle time, then counts the core's conversion-complete strobes over 2^AVG_LOG2 fixed windows.
- Averages the window counts and presents the result to the host over a valid/ready handshake.
- Sits between the host register interface and the sensor core controller; owns the core's reset line.

---
 rtl/tmp_meas_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_tmp_meas_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmp_meas_sched.sv
// -----------------------------------------------------------------------------
// tmp_meas_sched
//   Measurement scheduler for the switched-capacitor temperature-sensor core.
//   On a start request it pulses the core reset, waits for the core to settle,
//   counts conversion-complete strobes over 2^AVG_LOG2 windows of WIN_CYC
//   cycles, and hands the truncated average to the host over valid/ready.
//   A window with no strobes flags err and abandons the measurement.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   start       one-cycle measurement request (honoured in IDLE only)
//   cont        continuous mode, sampled when a result is accepted
//   evt         conversion-complete level from the core (rising edge = event)
//   sens_rst    holds the sensor core controller in reset
//   busy        high whenever not IDLE
//   data        averaged window count
//   data_valid  result available
//   data_ready  host accepts the result
//   err         sticky: some window ended with zero events
//   data_min    (TMP_MEAS_MINMAX_EN only) smallest window count of the result
//   data_max    (TMP_MEAS_MINMAX_EN only) largest window count of the result
//
// Build option
//   TMP_MEAS_MINMAX_EN  adds the data_min/data_max ports and their trackers.
// -----------------------------------------------------------------------------
module tmp_meas_sched #(
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 4096,
  parameter int SETTLE_CYC = 64,
  parameter int AVG_LOG2   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             evt,
  output logic             sens_rst,
  output logic             busy,
  output logic [CNT_W-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             err
`ifdef TMP_MEAS_MINMAX_EN
  ,
  output logic [CNT_W-1:0] data_min,
  output logic [CNT_W-1:0] data_max
`endif
);

  // One shared phase timer serves CORE_RST, SETTLE and WINDOW.
  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W   = CNT_W + AVG_LOG2;

  localparam logic [TMR_W-1:0] CRST_LAST   = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_CORE_RST, S_SETTLE, S_WINDOW, S_ACCUM, S_PRESENT
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   data_q, data_d;
  logic               err_q, err_d;
  logic               evt_prev_q, evt_prev_d;
  logic               evt_edge;
  logic [ACC_W-1:0]   acc_sum;
`ifdef TMP_MEAS_MINMAX_EN
  logic [CNT_W-1:0]   min_trk_q, min_trk_d, max_trk_q, max_trk_d;
  logic [CNT_W-1:0]   min_nxt, max_nxt;
  logic [CNT_W-1:0]   data_min_q, data_min_d, data_max_q, data_max_d;
`endif

  assign sens_rst   = (state_q == S_IDLE) || (state_q == S_CORE_RST);
  assign busy       = (state_q != S_IDLE);
  assign data_valid = (state_q == S_PRESENT);
  assign data       = data_q;
  assign err        = err_q;
`ifdef TMP_MEAS_MINMAX_EN
  assign data_min   = data_min_q;
  assign data_max   = data_max_q;
`endif

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    data_d     = data_q;
    err_d      = err_q;
    evt_prev_d = evt;
    evt_edge   = evt & ~evt_prev_q;
    acc_sum    = acc_q + ACC_W'(cnt_q);
`ifdef TMP_MEAS_MINMAX_EN
    min_trk_d  = min_trk_q;
    max_trk_d  = max_trk_q;
    data_min_d = data_min_q;
    data_max_d = data_max_q;
    min_nxt    = (cnt_q < min_trk_q) ? cnt_q : min_trk_q;
    max_nxt    = (cnt_q > max_trk_q) ? cnt_q : max_trk_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          acc_d   = '0;
          idx_d   = '0;
          tmr_d   = '0;
`ifdef TMP_MEAS_MINMAX_EN
          min_trk_d = CNT_MAX;
          max_trk_d = '0;
`endif
          state_d = S_CORE_RST;
        end
      end

      S_CORE_RST: begin
        if (tmr_q == CRST_LAST) begin
          tmr_d   = '0;
          state_d = S_SETTLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      // Edges are deliberately ignored while the core settles.
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = S_WINDOW;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      // The edge of the final window cycle still lands in cnt_q before ACCUM.
      S_WINDOW: begin
        if (evt_edge && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        if (tmr_q == WIN_LAST) begin
          tmr_d   = '0;
          state_d = S_ACCUM;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_ACCUM: begin
        if (cnt_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sum;
`ifdef TMP_MEAS_MINMAX_EN
          min_trk_d = min_nxt;
          max_trk_d = max_nxt;
`endif
          if (idx_q == LAST_IDX) begin
            data_d  = CNT_W'(acc_sum >> AVG_LOG2);
`ifdef TMP_MEAS_MINMAX_EN
            data_min_d = min_nxt;
            data_max_d = max_nxt;
`endif
            state_d = S_PRESENT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = '0;
            state_d = S_WINDOW;
          end
        end
      end

      S_PRESENT: begin
        if (data_ready) begin
          if (cont) begin
            acc_d   = '0;
            idx_d   = '0;
            tmr_d   = '0;
`ifdef TMP_MEAS_MINMAX_EN
            min_trk_d = CNT_MAX;
            max_trk_d = '0;
`endif
            state_d = S_CORE_RST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      evt_prev_q <= 1'b0;
`ifdef TMP_MEAS_MINMAX_EN
      min_trk_q  <= CNT_MAX;
      max_trk_q  <= '0;
      data_min_q <= '0;
      data_max_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      err_q      <= err_d;
      evt_prev_q <= evt_prev_d;
`ifdef TMP_MEAS_MINMAX_EN
      min_trk_q  <= min_trk_d;
      max_trk_q  <= max_trk_d;
      data_min_q <= data_min_d;
      data_max_q <= data_max_d;
`endif
    end
  end

endmodule

// File: tb/tb_tmp_meas_sched.sv
// -----------------------------------------------------------------------------
// tb_tmp_meas_sched
//   Self-checking bench for tmp_meas_sched. A timeline model (elapsed cycles
//   since a measurement began, per-window edge tallies) predicts every output
//   on every cycle; directed scenarios pin the model with literal values and a
//   second, narrow-counter instance exercises saturation.
// -----------------------------------------------------------------------------
module tb_tmp_meas_sched;

  localparam int CW   = 16;
  localparam int W    = 16;
  localparam int S    = 4;
  localparam int L2   = 2;
  localparam int N    = 1 << L2;
  localparam int LAT  = 2 + S + N * (W + 1);
  localparam int CMAX = (1 << CW) - 1;

  localparam int CW2  = 4;
  localparam int W2   = 40;
  localparam int LAT2 = 2 + S + N * (W2 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, cont, evt, data_ready;
  logic          sens_rst, busy, data_valid, err;
  logic [CW-1:0] data;

  logic           start2, evt2, ready2;
  logic           cont2 = 1'b0;
  logic           sens_rst2, busy2, data_valid2, err2;
  logic [CW2-1:0] data2;

`ifdef TMP_MEAS_MINMAX_EN
  logic [CW-1:0]  data_min, data_max;
  logic [CW2-1:0] data_min2, data_max2;
`endif

  tmp_meas_sched #(.CNT_W(CW), .WIN_CYC(W), .SETTLE_CYC(S), .AVG_LOG2(L2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .evt(evt),
    .sens_rst(sens_rst), .busy(busy), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .err(err)
`ifdef TMP_MEAS_MINMAX_EN
    , .data_min(data_min), .data_max(data_max)
`endif
  );

  tmp_meas_sched #(.CNT_W(CW2), .WIN_CYC(W2), .SETTLE_CYC(S), .AVG_LOG2(L2)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start2), .cont(cont2), .evt(evt2),
    .sens_rst(sens_rst2), .busy(busy2), .data(data2), .data_valid(data_valid2),
    .data_ready(ready2), .err(err2)
`ifdef TMP_MEAS_MINMAX_EN
    , .data_min(data_min2), .data_max(data_max2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc, hs_cyc, dv_rise_cyc, sr_fall_cyc;
  bit dv_prev = 1'b0;
  bit sr_prev = 1'b1;
  int plan_cnt [N];
  bit noise;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_active = 1'b0, m_present = 1'b0, m_err = 1'b0, m_evt_prev = 1'b0;
  int            m_e = 0;
  int            m_cnt [N];
  logic [CW-1:0] m_data = '0, m_min = '0, m_max = '0;

  function automatic void m_begin();
    m_active  = 1'b1;
    m_present = 1'b0;
    m_e       = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endfunction

  // Advance the model by one clock edge given the inputs sampled at it.
  // m_e is the number of edges since the one that launched the measurement:
  // positions 0-1 core reset, then S settle cycles, then per window W counting
  // cycles plus one accumulate cycle.
  function automatic void model_step(input bit rst, input bit st, input bit ct,
                                     input bit ev, input bit rdy);
    int p, q, j, o, sum, mn, mx;
    bit rise;
    if (rst) begin
      m_active = 0; m_present = 0; m_err = 0; m_evt_prev = 0;
      m_data = '0; m_min = '0; m_max = '0;
      return;
    end
    rise = ev && !m_evt_prev;
    m_evt_prev = ev;
    if (m_present) begin
      if (rdy) begin
        m_present = 1'b0;
        if (ct) m_begin();
      end
    end else if (m_active) begin
      p = m_e;
      m_e++;
      if (p >= 2 + S) begin
        q = p - 2 - S;
        j = q / (W + 1);
        o = q % (W + 1);
        if (o < W) begin
          if (rise && m_cnt[j] < CMAX) m_cnt[j]++;
        end else if (m_cnt[j] == 0) begin
          m_err = 1'b1;
          m_active = 1'b0;
        end else if (j == N - 1) begin
          sum = 0; mn = CMAX; mx = 0;
          foreach (m_cnt[i]) begin
            sum += m_cnt[i];
            if (m_cnt[i] < mn) mn = m_cnt[i];
            if (m_cnt[i] > mx) mx = m_cnt[i];
          end
          m_data = CW'(sum >> L2);
          m_min  = CW'(mn);
          m_max  = CW'(mx);
          m_present = 1'b1;
          m_active  = 1'b0;
        end
      end
    end else if (st) begin
      m_err = 1'b0;
      m_begin();
    end
  endfunction

  // One clock: update the model with the inputs the DUT sees at this edge,
  // then compare every output shortly after the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(reset, start, cont, evt, data_ready);
    #1;
    check("sens_rst", sens_rst, !m_present && (!m_active || m_e < 2));
    check("busy", busy, m_active || m_present);
    check("data_valid", data_valid, m_present);
    check("data", data, m_data);
    check("err", err, m_err);
`ifdef TMP_MEAS_MINMAX_EN
    check("data_min", data_min, m_min);
    check("data_max", data_max, m_max);
`endif
    if (data_valid && !dv_prev) dv_rise_cyc = cyc;
    if (!sens_rst && sr_prev) sr_fall_cyc = cyc;
    dv_prev = data_valid;
    sr_prev = sens_rst;
  endtask

  // evt level for the cycle at timeline position p: optional toggling during
  // settle, and plan_cnt[j] single-cycle pulses at odd offsets of window j.
  function automatic bit plan_evt(input int p);
    int q, j, o;
    if (p < 2) return 1'b0;
    if (p < 2 + S) return noise && (p % 2 == 1);
    q = p - 2 - S;
    j = q / (W + 1);
    o = q % (W + 1);
    if (j >= N || o >= W) return 1'b0;
    return (o % 2 == 1) && ((o - 1) / 2 < plan_cnt[j]);
  endfunction

  task automatic run_body(input int stop);
    for (int p = 0; p < stop; p++) begin
      evt = plan_evt(p);
      tick();
    end
    evt = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic handshake(input int hold);
    data_ready = 1'b0;
    repeat (hold) tick();
    data_ready = 1'b1;
    tick();
    hs_cyc = cyc;
    data_ready = 1'b0;
  endtask

  initial begin
    int mode;
    reset = 1'b1; start = 1'b0; cont = 1'b0; evt = 1'b0; data_ready = 1'b0;
    start2 = 1'b0; evt2 = 1'b0; ready2 = 1'b0;
    noise = 1'b0;
    tick(); tick();
    check("rst_sens_rst", sens_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    tick();

    // 1. basic average: 3+4+5+6 = 18 -> 4, settle toggles ignored
    plan_cnt = '{3, 4, 5, 6}; noise = 1'b1;
    kick();
    run_body(LAT);
    check("t1_model_data", m_data, 4);
    check("t1_data", data, 4);
    check("t1_latency", dv_rise_cyc - start_cyc, 74);
    check("t1_sens_fall", sr_fall_cyc - start_cyc, 2);
    check("t1_err", err, 0);
    handshake(0);

    // 2. backpressure: 8+1+1+1 = 11 -> 2, held for 20 cycles
    plan_cnt = '{8, 1, 1, 1}; noise = 1'b0;
    kick();
    run_body(LAT);
    data_ready = 1'b0;
    repeat (20) tick();
    check("t2_valid_held", data_valid, 1);
    check("t2_data_held", data, 2);
    handshake(0);
    check("t2_busy_after", busy, 0);
    check("t2_valid_after", data_valid, 0);
    check("t2_data_kept", data, 2);

    // 3. empty second window: err, no result, back to IDLE
    plan_cnt = '{5, 0, 3, 3}; noise = 1'b1;
    kick();
    run_body(LAT);
    check("t3_model_err", m_err, 1);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_no_valid", data_valid, 0);
    check("t3_data_kept", data, 2);
    kick();
    check("t3_err_cleared", err, 0);

    // 4. continuous mode, 8 edges per window (last one in the final cycle)
    plan_cnt = '{8, 8, 8, 8}; noise = 1'b0; cont = 1'b1;
    run_body(LAT);
    check("t4_data_a", data, 8);
    handshake(0);
    run_body(LAT);
    check("t4_valid_b", data_valid, 1);
    check("t4_data_b", data, 8);
    check("t4_restart_lat", dv_rise_cyc - hs_cyc, 74);
    check("t4_core_rst_len", sr_fall_cyc - hs_cyc, 2);
    cont = 1'b0;
    handshake(3);
    tick();
    check("t4_idle", busy, 0);

    // 5. reset in the middle of window 2, then a fresh measurement
    plan_cnt = '{4, 4, 4, 4};
    kick();
    run_body(2 + S + (W + 1) + 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_sens_rst", sens_rst, 1);
    check("t5_busy", busy, 0);
    check("t5_data", data, 0);
    check("t5_valid", data_valid, 0);
    check("t5_err", err, 0);
    repeat (3) tick();
    plan_cnt = '{2, 7, 1, 5}; noise = 1'b1;
    kick();
    run_body(LAT);
    check("t5_model_data", m_data, 3);
    check("t5_data", data, 3);
    handshake(1);

    // 6. saturation: 20 edges per 40-cycle window on a 4-bit counter -> 15
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int p = 0; p < LAT2; p++) begin
      int q, o;
      if (p < 2 + S) begin
        evt2 = (p >= 2) && (p % 2 == 1);
      end else begin
        q = p - 2 - S;
        o = q % (W2 + 1);
        evt2 = (o < W2) && (o % 2 == 1);
      end
      tick();
      if (p == LAT2 - 2) check("t6_valid_early", data_valid2, 0);
    end
    evt2 = 1'b0;
    check("t6_valid", data_valid2, 1);
    check("t6_data_sat", data2, 15);
    check("t6_err", err2, 0);
    check("t6_busy", busy2, 1);
    check("t6_sens_rst", sens_rst2, 0);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    check("t6_valid_after", data_valid2, 0);
    check("t6_busy_after", busy2, 0);
    check("t6_sens_rst_after", sens_rst2, 1);
    check("t6_data_kept", data2, 15);

    // random traffic: quiet epochs starve windows, starts land anywhere
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mode = $urandom_range(0, 3);
      evt        = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      start      = ($urandom_range(0, 31) == 0);
      cont       = 1'($urandom_range(0, 1));
      data_ready = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 999) == 0);
      tick();
    end
    start = 1'b0; cont = 1'b0; reset = 1'b0; data_ready = 1'b1;
    for (int i = 0; i < 300 && (m_active || m_present); i++) begin
      evt = 1'($urandom_range(0, 1));
      tick();
    end
    data_ready = 1'b0;
    evt = 1'b0;
    tick();
    check("drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
